// File: rtl/blowfish_expand_ctrl_if.sv
// rtl/blowfish_expand_ctrl_if.sv - feistel engine handshake and shared dual-port SRAM bundle
interface blowfish_expand_ctrl_if;
    logic        f_start;
    logic [31:0] f_L;
    logic [31:0] f_R;
    logic [31:0] f_resultL;
    logic [31:0] f_resultR;
    logic        f_done;
    logic [11:0] f_addr_a;
    logic [11:0] f_addr_b;
    logic        f_cs_a_l, f_we_a_l, f_oe_a_l;
    logic        f_cs_b_l, f_we_b_l, f_oe_b_l;
    logic [11:0] addr_a;
    logic [11:0] addr_b;
    logic        cs_a_l, we_a_l, oe_a_l;
    logic        cs_b_l, we_b_l, oe_b_l;
    logic [31:0] wdata_a;
    logic [31:0] wdata_b;
    logic [31:0] data_a;

    modport master (
        output f_start, f_L, f_R,
        input  f_resultL, f_resultR, f_done,
        input  f_addr_a, f_addr_b, f_cs_a_l, f_we_a_l, f_oe_a_l, f_cs_b_l, f_we_b_l, f_oe_b_l,
        output addr_a, addr_b, cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l,
        output wdata_a, wdata_b,
        input  data_a
    );

    modport slave (
        input  f_start, f_L, f_R,
        output f_resultL, f_resultR, f_done,
        output f_addr_a, f_addr_b, f_cs_a_l, f_we_a_l, f_oe_a_l, f_cs_b_l, f_we_b_l, f_oe_b_l,
        input  addr_a, addr_b, cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l,
        input  wdata_a, wdata_b,
        output data_a
    );
endinterface

// File: rtl/blowfish_expand_ctrl.sv
// rtl/blowfish_expand_ctrl.sv - Blowfish/bcrypt key-expansion sequencer around the feistel engine
// Optional busy-cycle counter port o_cycles when EXPAND_PERF_EN is defined.
module blowfish_expand_ctrl #(
    parameter int P_ARRAY_OFFSET = 4000,
    parameter int S_WORDS        = 1024,
    parameter int KEY_WORDS      = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_salt_en,
    input  logic [127:0]           i_salt,
    output logic [4:0]             o_key_idx,
    input  logic [31:0]            i_key_data,
    output logic                   o_busy,
    output logic                   o_done,
`ifdef EXPAND_PERF_EN
    output logic [15:0]            o_cycles,
`endif
    blowfish_expand_ctrl_if.master bus
);

    localparam logic [11:0] P_BASE   = 12'(P_ARRAY_OFFSET);
    localparam logic [9:0]  LAST_BLK = 10'(9 + S_WORDS / 2 - 1);
    localparam logic [4:0]  KEY_LAST = 5'(KEY_WORDS - 1);
    localparam logic [4:0]  P_LAST   = 5'd17;

    typedef enum logic [2:0] {
        S_IDLE, S_KX_RD, S_KX_WR, S_ENC_START, S_ENC_WAIT, S_ENC_WB, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_i, r_kidx;
    logic [9:0]  r_blk;
    logic [31:0] r_L, r_R;
    logic        r_salt_en;
    logic [31:0] w_salt_l, w_salt_r;
    logic [11:0] w_dest;
    logic        w_busy;

    assign w_salt_l  = r_salt_en ? (r_blk[0] ? i_salt[127:96] : i_salt[63:32]) : 32'd0;
    assign w_salt_r  = r_salt_en ? (r_blk[0] ? i_salt[95:64]  : i_salt[31:0])  : 32'd0;
    // First 9 blocks refill the P-array, the remaining blocks walk the S-boxes from address 0.
    assign w_dest    = (r_blk < 10'd9) ? P_BASE + {1'b0, r_blk, 1'b0} : {1'b0, r_blk - 10'd9, 1'b0};
    assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_key_idx = r_kidx;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_next = S_KX_RD;
            S_KX_RD:     w_next = S_KX_WR;
            S_KX_WR:     w_next = (r_i == P_LAST) ? S_ENC_START : S_KX_RD;
            S_ENC_START: w_next = S_ENC_WAIT;
            S_ENC_WAIT:  if (bus.f_done) w_next = S_ENC_WB;
            S_ENC_WB:    w_next = (r_blk == LAST_BLK) ? S_DONE : S_ENC_START;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_i <= '0; r_kidx <= '0; r_blk <= '0;
            r_L <= '0; r_R <= '0; r_salt_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_i <= '0; r_kidx <= '0; r_blk <= '0;
                    r_L <= '0; r_R <= '0; r_salt_en <= i_salt_en;
                end
                S_KX_WR: if (r_i != P_LAST) begin
                    r_i    <= r_i + 5'd1;
                    r_kidx <= (r_kidx == KEY_LAST) ? 5'd0 : r_kidx + 5'd1;
                end
                S_ENC_WAIT: if (bus.f_done) begin
                    r_L <= bus.f_resultL;
                    r_R <= bus.f_resultR;
                end
                S_ENC_WB: if (r_blk != LAST_BLK) r_blk <= r_blk + 10'd1;
                default: ;
            endcase
        end
    end

    // Outputs are forced idle while reset is low so an abort never leaks a write strobe.
    always_comb begin
        o_busy = 1'b0; o_done = 1'b0;
        bus.f_start = 1'b0; bus.f_L = '0; bus.f_R = '0;
        bus.addr_a = '0; bus.cs_a_l = 1'b1; bus.we_a_l = 1'b1; bus.oe_a_l = 1'b0; bus.wdata_a = '0;
        bus.addr_b = '0; bus.cs_b_l = 1'b1; bus.we_b_l = 1'b1; bus.oe_b_l = 1'b0; bus.wdata_b = '0;
        if (reset) begin
            o_busy = w_busy;
            o_done = (r_state == S_DONE);
            case (r_state)
                S_KX_RD: begin
                    bus.cs_a_l = 1'b0;
                    bus.addr_a = P_BASE + {7'd0, r_i};
                end
                S_KX_WR: begin
                    bus.cs_a_l  = 1'b0; bus.we_a_l = 1'b0; bus.oe_a_l = 1'b1;
                    bus.addr_a  = P_BASE + {7'd0, r_i};
                    bus.wdata_a = bus.data_a ^ i_key_data;
                end
                S_ENC_START, S_ENC_WAIT: begin
                    bus.f_start = (r_state == S_ENC_START);
                    bus.f_L = r_L ^ w_salt_l;
                    bus.f_R = r_R ^ w_salt_r;
                    bus.addr_a = bus.f_addr_a; bus.cs_a_l = bus.f_cs_a_l;
                    bus.we_a_l = bus.f_we_a_l; bus.oe_a_l = bus.f_oe_a_l;
                    bus.addr_b = bus.f_addr_b; bus.cs_b_l = bus.f_cs_b_l;
                    bus.we_b_l = bus.f_we_b_l; bus.oe_b_l = bus.f_oe_b_l;
                end
                S_ENC_WB: begin
                    bus.cs_a_l = 1'b0; bus.we_a_l = 1'b0; bus.oe_a_l = 1'b1;
                    bus.cs_b_l = 1'b0; bus.we_b_l = 1'b0; bus.oe_b_l = 1'b1;
                    bus.addr_a = w_dest; bus.addr_b = w_dest + 12'd1;
                    bus.wdata_a = r_L;   bus.wdata_b = r_R;
                end
                default: ;
            endcase
        end
    end

`ifdef EXPAND_PERF_EN
    logic [15:0] r_cycles;
    always_ff @(posedge clk) begin
        if (!reset)                            r_cycles <= '0;
        else if (r_state == S_IDLE && i_start) r_cycles <= '0;
        else if (w_busy && r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
    end
    assign o_cycles = r_cycles;
`endif

endmodule
